// File: rtl/line_buffer_controller_pkg.sv
// ----------------------------------------------------------------------------
// line_buffer_controller_pkg
// Shared definitions for the line-buffer controller and its datapath:
//   - FSM state encoding
//   - derived geometry helpers (padded width, dilated kernel span,
//     output frame size, number of taps blanked at the first output row)
// ----------------------------------------------------------------------------
package line_buffer_controller_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lbc_state_t;

    // Padded frame width: left and right padding columns added.
    function automatic int calc_tw(input int in_width, input int pad_col);
        return in_width + 2 * pad_col;
    endfunction

    // Footprint of a dilated kernel along one axis.
    function automatic int calc_span(input int kernel, input int dilation);
        return dilation * (kernel - 1) + 1;
    endfunction

    function automatic int calc_out_h(input int in_height, input int pad_row, input int w0);
        return in_height + 2 * pad_row - w0 + 1;
    endfunction

    function automatic int calc_out_w(input int tw, input int w1);
        return tw - w1 + 1;
    endfunction

    // Taps that fall into the (never pushed) top padding on the first output
    // row; the datapath uses this to size its blank-injection logic.
    function automatic int calc_blank_taps(input int k0, input int k1,
                                           input int d0, input int p0);
        int n;
        n = 0;
        for (int i = 0; i < k0; i++) begin
            if (i * d0 < p0) n += k1;
        end
        return n;
    endfunction

endpackage

// File: rtl/line_buffer_controller_if.sv
// ----------------------------------------------------------------------------
// line_buffer_controller_if
// Streaming handshake bundle between the controller, the pixel source and
// the window consumer.
//   i_valid/i_ready     : upstream pixel handshake
//   o_valid/o_ready     : downstream window handshake, o_last marks the end
//   shift, is_padding   : datapath advance / inject zero pixel
//   out_blank[NTAPS]    : per-tap mask for the current window
// master = controller side, slave = environment side.
// ----------------------------------------------------------------------------
interface line_buffer_controller_if #(
    parameter int NTAPS = 9
);
    logic             i_valid;
    logic             i_ready;
    logic             o_valid;
    logic             o_ready;
    logic             o_last;
    logic             shift;
    logic             is_padding;
    logic [NTAPS-1:0] out_blank;

    modport master (
        input  i_valid, o_ready,
        output i_ready, o_valid, o_last, shift, is_padding, out_blank
    );

    modport slave (
        output i_valid, o_ready,
        input  i_ready, o_valid, o_last, shift, is_padding, out_blank
    );
endinterface

// File: rtl/line_buffer_pos_counter.sv
// ----------------------------------------------------------------------------
// line_buffer_pos_counter
// Padded-frame position counter (pr = padded row, pc = padded column).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart at (PR_INIT, 0)
//   en         : advance one position, pc wraps TW-1 -> 0 and bumps pr
//   pr, pc     : current position
//   last       : current position is the final pushed one
//   past       : counter has moved beyond the final position
// ----------------------------------------------------------------------------
module line_buffer_pos_counter #(
    parameter int TW      = 8,
    parameter int ROWS    = 8,
    parameter int PR_INIT = 2,
    parameter int PR_W    = 4,
    parameter int PC_W    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            en,
    output logic [PR_W-1:0] pr,
    output logic [PC_W-1:0] pc,
    output logic            last,
    output logic            past
);
    logic [PR_W-1:0] pr_reg, pr_next;
    logic [PC_W-1:0] pc_reg, pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_reg <= PR_W'(PR_INIT);
            pc_reg <= '0;
        end else begin
            pr_reg <= pr_next;
            pc_reg <= pc_next;
        end
    end

    always_comb begin
        pr_next = pr_reg;
        pc_next = pc_reg;
        if (load) begin
            pr_next = PR_W'(PR_INIT);
            pc_next = '0;
        end else if (en) begin
            if (pc_reg == PC_W'(TW - 1)) begin
                pc_next = '0;
                pr_next = pr_reg + PR_W'(1);
            end else begin
                pc_next = pc_reg + PC_W'(1);
            end
        end
    end

    assign pr   = pr_reg;
    assign pc   = pc_reg;
    assign last = (pr_reg == PR_W'(ROWS - 1)) && (pc_reg == PC_W'(TW - 1));
    assign past = (pr_reg >= PR_W'(ROWS));

endmodule

// File: rtl/line_buffer_controller.sv
// ----------------------------------------------------------------------------
// line_buffer_controller
// Sequences a dilated, padded sliding-window line buffer over one frame.
// Walks the padded frame (top padding rows skipped), requests pixels at real
// positions, injects zeros at padding positions and flags each complete
// window together with a per-tap blank mask for taps that would read the
// unpushed top padding.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : frame start pulse (ignored while busy)
//   busy        : frame in progress
//   done        : one-cycle pulse after the last window handshake
//   bus         : streaming handshake bundle (master side)
// ----------------------------------------------------------------------------
module line_buffer_controller
    import line_buffer_controller_pkg::*;
#(
    parameter int IN_WIDTH   = 512,
    parameter int IN_HEIGHT  = 256,
    parameter int KERNEL_0   = 3,
    parameter int KERNEL_1   = 3,
    parameter int DILATION_0 = 2,
    parameter int DILATION_1 = 2,
    parameter int PADDING_0  = 2,
    parameter int PADDING_1  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    line_buffer_controller_if.master bus
);
    localparam int TW    = calc_tw(IN_WIDTH, PADDING_1);
    localparam int W0    = calc_span(KERNEL_0, DILATION_0);
    localparam int W1    = calc_span(KERNEL_1, DILATION_1);
    localparam int ROWS  = IN_HEIGHT + 2 * PADDING_0;
    localparam int NTAPS = KERNEL_0 * KERNEL_1;
    localparam int PR_W  = $clog2(ROWS + 1);
    localparam int PC_W  = (TW > 1) ? $clog2(TW) : 1;

    lbc_state_t       state_reg, state_next;
    logic             o_valid_reg, o_valid_next;
    logic             o_last_reg, o_last_next;
    logic [NTAPS-1:0] out_blank_reg, out_blank_next;
    logic             done_reg, done_next;

    logic [PR_W-1:0]  pr;
    logic [PC_W-1:0]  pc;
    logic             pos_last, pos_past;
    logic             run, pad_pos, adv, shift_int, win_hit, last_hs;
    logic [NTAPS-1:0] blank_calc;

    line_buffer_pos_counter #(
        .TW      (TW),
        .ROWS    (ROWS),
        .PR_INIT (PADDING_0),
        .PR_W    (PR_W),
        .PC_W    (PC_W)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .load  ((state_reg == IDLE) && start),
        .en    (shift_int),
        .pr    (pr),
        .pc    (pc),
        .last  (pos_last),
        .past  (pos_past)
    );

    assign run     = (state_reg == RUN);
    assign pad_pos = (int'(pc) < PADDING_1) ||
                     (int'(pc) >= PADDING_1 + IN_WIDTH) ||
                     (int'(pr) >= PADDING_0 + IN_HEIGHT);
    // A pending window blocks advancing until the consumer takes it, so the
    // datapath never overwrites a window that is still being presented.
    assign adv       = run && !pos_past && (!o_valid_reg || bus.o_ready);
    assign shift_int = adv && (pad_pos || bus.i_valid);
    assign win_hit   = shift_int && (int'(pr) >= W0 - 1) && (int'(pc) >= W1 - 1);
    assign last_hs   = o_valid_reg && bus.o_ready && o_last_reg;

    // Window top row is pr-(W0-1); kernel row i sits i*DILATION_0 below it.
    // Rows above PADDING_0 were never pushed, so their stale FIFO content
    // must be masked.
    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_blank
            localparam int ROW_OFF = (gi / KERNEL_1) * DILATION_0;
            assign blank_calc[gi] = (int'(pr) - (W0 - 1) + ROW_OFF) < PADDING_0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            o_valid_reg   <= 1'b0;
            o_last_reg    <= 1'b0;
            out_blank_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            o_valid_reg   <= o_valid_next;
            o_last_reg    <= o_last_next;
            out_blank_reg <= out_blank_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        done_next      = 1'b0;
        o_valid_next   = o_valid_reg;
        o_last_next    = o_last_reg;
        out_blank_next = out_blank_reg;

        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (last_hs) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (o_valid_reg && bus.o_ready) begin
            o_valid_next = 1'b0;
            o_last_next  = 1'b0;
        end
        // A newly completed window takes priority over the consumer clear.
        if (win_hit) begin
            o_valid_next   = 1'b1;
            o_last_next    = pos_last;
            out_blank_next = blank_calc;
        end
    end

    assign busy           = run;
    assign done           = done_reg;
    assign bus.i_ready    = adv && !pad_pos;
    assign bus.shift      = shift_int;
    assign bus.is_padding = run && pad_pos;
    assign bus.o_valid    = o_valid_reg;
    assign bus.o_last     = o_last_reg;
    assign bus.out_blank  = out_blank_reg;

endmodule

// File: doc/line_buffer_controller.md
LINE_BUFFER_CONTROLLER -- requirements
Module: line_buffer_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IN_WIDTH 512: input frame width, pixels
- IN_HEIGHT 256: input frame height, rows
- KERNEL_0 3, KERNEL_1 3: kernel rows and columns
- DILATION_0 2, DILATION_1 2: row and column dilation
- PADDING_0 2, PADDING_1 2: top/bottom padding and left/right padding
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1: the single clock
- rst_n in 1: asynchronous active-low reset
- start in 1: frame start pulse
- busy out 1: frame in progress
- done out 1: one-cycle pulse at frame end
- i_valid in 1: upstream pixel valid
- i_ready out 1: upstream pixel accepted
- o_valid out 1: datapath window valid
- o_ready in 1: downstream accepts window
- o_last out 1: final window of the frame
- shift out 1: datapath advance
- is_padding out 1: datapath injects a zero pixel
- out_blank out KERNEL_0*KERNEL_1: per-tap mask; the integrator connects only the low bits the datapath uses.

Function
REQ-003 Derived values: TW=IN_WIDTH+2*PADDING_1; W0=DILATION_0*(KERNEL_0-1)+1; W1=DILATION_1*(KERNEL_1-1)+1; OUT_H=IN_HEIGHT+2*PADDING_0-W0+1; OUT_W=TW-W1+1.
REQ-004 FSM states: IDLE, RUN.
- IDLE->RUN on start.
- RUN->IDLE when the o_last window handshakes (o_valid&o_ready&o_last).
- start is ignored while in RUN.
REQ-005 Position counters pr (padded row) and pc (padded column), updated only on shift.
- On entering RUN: pr=PADDING_0, pc=0. Top padding rows are never pushed.
- pc wraps TW-1->0 and pr then increments.
- Last pushed position is pr=IN_HEIGHT+2*PADDING_0-1, pc=TW-1.
REQ-006 pad_pos = (pc<PADDING_1) | (pc>=PADDING_1+IN_WIDTH) | (pr>=PADDING_0+IN_HEIGHT). is_padding=pad_pos in RUN, else 0.
REQ-007 adv = RUN & not past last position & (!o_valid | o_ready).
REQ-008 i_ready = adv & !pad_pos. shift = adv & (pad_pos | i_valid). i_ready never depends on i_valid.
REQ-009 o_valid is registered and set on a shift at position (pr,pc) with pr>=W0-1 and pc>=W1-1. It stays 1 until o_ready; a new setting shift overrides the clear in the same cycle.
REQ-010 out_blank is registered with o_valid. Tap k (row i=k/KERNEL_1) is blanked iff pr-(W0-1)+i*DILATION_0 < PADDING_0.
REQ-011 o_last is registered with o_valid: 1 when the window is at the last position.
REQ-012 Per frame: exactly IN_HEIGHT*IN_WIDTH input handshakes, OUT_H*OUT_W o_valid handshakes and (IN_HEIGHT+PADDING_0)*TW shifts.
REQ-013 done pulses one cycle on the RUN->IDLE transition. busy = (state==RUN).
REQ-014 Back-to-back frames: start may be asserted in the same cycle as done, and RUN is then re-entered the next cycle. Datapath FIFO contents carry over and are masked by REQ-010.
REQ-015 o_ready held low stalls all shifts with no loss; i_valid low at a non-padding position stalls without advancing.

Reset
REQ-016 rst_n low asynchronously forces:
- state=IDLE, pr=PADDING_0, pc=0
- o_valid=0, o_last=0, out_blank=0, done=0
- combinationally shift=0, i_ready=0, is_padding=0
REQ-017 Reset mid-frame abandons the frame. The next start begins a fresh frame with no residual o_valid.

Structure
REQ-018 A shared package holds the derived-size functions (TW, W0, W1, OUT_H, OUT_W, blank-point count) and the state encoding, for use by both this block and the datapath.
REQ-019 One sub-module, line_buffer_pos_counter, holds the pr/pc wrap counter with an enable input and last-position flag output.

Verification (IN_WIDTH=4, IN_HEIGHT=4, K=3, D=2, P=2: TW=8, OUT 4x4)
REQ-020 start, i_valid=1, o_ready=1 always -> 48 shifts, 16 i_ready handshakes, 16 windows, o_last on the 16th, done one cycle after it.
REQ-021 First window -> produced by the 21st shift (pr=4, pc=4), out_blank=9'b000000111. The window at pr=6 -> out_blank=0.
REQ-022 o_ready=0 for 10 cycles while o_valid=1 -> shift=0 and i_ready=0 throughout, window data and out_blank stable.
REQ-023 i_valid toggled randomly -> padding positions still advance, pixel order preserved, 16 inputs consumed.
REQ-024 rst_n pulsed after the 30th shift -> all outputs at reset values immediately. A new start then reproduces REQ-020 exactly.
REQ-025 start asserted with done, two frames back to back -> 32 windows, out_blank of the second frame's first window = 9'b000000111.
